ll_ht_res_sink: RTL and testbench
=================================

# ll_ht_res_sink

Receiving end of the linked-list hash-table result interface (`ll_ht_res_if`). It acts as the slave modport and accepts `ll_ht_result_t` beats from the hash-table engine into a small first-word-fall-through buffer. It re-presents the beats on a plain valid/ready stream toward the lock-manager response path. It also keeps wrap-around statistics counters and supports a synchronous flush for abort and recovery.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; power of two, minimum 2.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ht_res`  `ll_ht_res_if.slave`  –  incoming results; the block drives `ready` and samples `result` and `valid`.
- `out_result`  out  `ll_ht_result_t`  head-of-buffer result.
- `out_valid`  out  1  `out_result` is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `flush`  in  1  synchronous discard of all buffered entries.
- `level`  out  `$clog2(DEPTH+1)`  current occupancy.
- `cnt_in`  out  `CNT_W`  beats accepted from `ht_res`.
- `cnt_out`  out  `CNT_W`  beats delivered on `out_*`.
- `cnt_drop`  out  `CNT_W`  beats discarded by `flush`.

## Operation
- Push: `ht_res.valid && ht_res.ready` writes `ht_res.result` at the write pointer and increments `cnt_in`.
- Pop: `out_valid && out_ready` advances the read pointer and increments `cnt_out`.
- `ht_res.ready = !full && !flush`. This is combinational on `flush` and otherwise derived from registered state only; it is never a function of `ht_res.valid`.
- `out_valid = !empty && !flush`. `out_result` is the entry at the read pointer; its contents are don't-care while `out_valid` is low.
- Simultaneous push and pop when not full and not empty: `level` is unchanged and both counters increment.
- Full: no push occurs, because `ready` is low. A pop in the same cycle frees a slot, but `ready` rises only in the next cycle; there is no full-cycle pass-through.
- Empty: no pop occurs. A push into an empty buffer becomes visible on `out_valid` in the next cycle; there is no combinational bypass.
- Flush: in the cycle `flush` is high, no push and no pop occur. At the next edge, pointers and `level` go to 0 and `cnt_drop` increases by the pre-flush `level`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; full and empty are decoded from `level`.
- All counters wrap modulo 2^CNT_W with no saturation.
- Invariant: `cnt_in - cnt_out - cnt_drop == level`, taken modulo 2^CNT_W.
- Storage is an unreset register array; only control state is reset.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - `level` = 0, pointers = 0;
  - `cnt_in` = `cnt_out` = `cnt_drop` = 0;
  - `out_valid` = 0;
  - `ht_res.ready` = 1 in the first cycle after release, when `flush` is 0.
- Reset mid-transfer discards all buffered beats and does not count them as drops.
- Latency from push to `out_valid` is 1 cycle. Sustained throughput is 1 beat per cycle when `DEPTH >= 2` and `out_ready` is held high.
- Handshake rules on both sides:
  - A beat transfers on a rising edge with valid and ready both high.
  - Once `out_valid` is high, `out_result` stays stable until it is accepted or flushed.
  - Upstream may hold `valid` high indefinitely; deasserting it is legal.
- Counters and `level` are registered and reflect a transfer in the cycle after it.

## Structure
- `ll_ht_result_t` stays in package `linked_list`.
- Add `LL_RES_CNT_W = 32` to the same package and use it as the `CNT_W` default.
- One sub-module, `ll_res_fifo`, is natural. It is a generic parameterised FWFT FIFO with flush and level outputs, type-parameterised on the entry type.
- `ll_ht_res_sink` instantiates `ll_res_fifo`, wraps it with the interface connections and the gating, and holds the counters.

## Test plan
- Basic transfer: reset, then push results A, B, C with `out_ready = 1`. Expect A, B, C on `out_result` in order, each 1 cycle after push; final `cnt_in` = `cnt_out` = 3.
- Fill: hold `out_ready = 0` and push 5 beats with `DEPTH = 4`. Expect `ht_res.ready` to drop after the 4th accept, `level` = 4, and the 5th beat held upstream. Raise `out_ready` for one cycle; `ready` returns in the following cycle.
- Streaming: drive continuous valid on both sides for 100 cycles. Expect 1 beat per cycle after the first, `level <= 1`, and `cnt_in - cnt_out == level` throughout.
- Flush: with 3 entries buffered, pulse `flush` while `ht_res.valid = 1`. Expect no accept that cycle, `level` = 0 and `cnt_drop` = 3 afterwards, and no flushed entry appearing on `out_*`.
- Reset mid-operation: assert `rst_n = 0` asynchronously with 2 entries buffered. Expect `out_valid` to fall immediately and all counters = 0 after release.
- Wrap: use `CNT_W = 4` and transfer 18 beats. Expect `cnt_in` = `cnt_out` = 2.

Source files
------------

// File: rtl/ll_ht_res_sink_pkg.sv
// Shared types for the linked-list hash-table result path.
// Result beat layout and statistics counter width.
package linked_list;

  localparam int LL_RES_CNT_W = 32;
  localparam int LL_TXN_W     = 8;
  localparam int LL_VAL_W     = 32;

  typedef enum logic [1:0] {
    LL_HT_HIT      = 2'd0,
    LL_HT_MISS     = 2'd1,
    LL_HT_INSERTED = 2'd2,
    LL_HT_ERR      = 2'd3
  } ll_ht_status_e;

  typedef struct packed {
    logic [LL_TXN_W-1:0] txn_id;
    ll_ht_status_e       status;
    logic [LL_VAL_W-1:0] value;
  } ll_ht_result_t;

endpackage

// File: rtl/ll_ht_res_if.sv
// Result stream from the hash-table engine.
// Master drives result/valid, slave drives ready.
interface ll_ht_res_if;
  import linked_list::*;

  ll_ht_result_t result;
  logic          valid;
  logic          ready;

  modport master (
    output result,
    output valid,
    input  ready
  );

  modport slave (
    input  result,
    input  valid,
    output ready
  );

endinterface

// File: rtl/ll_res_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush.
// Full/empty decode from the occupancy count; pointers wrap naturally.
module ll_res_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  T mem_q [DEPTH];

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage carries no reset; validity lives in level_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ll_ht_res_sink.sv
// Sink for hash-table results: buffers beats, re-presents them
// downstream, and keeps wrap-around in/out/drop statistics.
module ll_ht_res_sink
  import linked_list::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = LL_RES_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ll_ht_res_if.slave                 ht_res,
  output ll_ht_result_t              out_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           cnt_in,
  output logic [CNT_W-1:0]           cnt_out,
  output logic [CNT_W-1:0]           cnt_drop
);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_in_q, cnt_in_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  assign ht_res.ready = !full && !flush;
  assign out_valid    = !empty && !flush;
  assign push         = ht_res.valid && ht_res.ready;
  assign pop          = out_valid && out_ready;

  ll_res_fifo #(
    .T     (ll_ht_result_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (ht_res.result),
    .pop   (pop),
    .rdata (out_result),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Drops count whatever was still buffered when flush hit.
  always_comb begin
    cnt_in_d   = cnt_in_q + CNT_W'(push);
    cnt_out_d  = cnt_out_q + CNT_W'(pop);
    cnt_drop_d = cnt_drop_q;
    if (flush) cnt_drop_d = cnt_drop_q + CNT_W'(level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_in_q   <= '0;
      cnt_out_q  <= '0;
      cnt_drop_q <= '0;
    end else begin
      cnt_in_q   <= cnt_in_d;
      cnt_out_q  <= cnt_out_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign cnt_in   = cnt_in_q;
  assign cnt_out  = cnt_out_q;
  assign cnt_drop = cnt_drop_q;

endmodule

// File: tb/tb_ll_ht_res_sink.sv
// Bench for ll_ht_res_sink: queue scoreboard plus per-cycle
// vector table and directed multi-cycle sequences.
module tb_ll_ht_res_sink;
  import linked_list::*;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ll_ht_res_if if_m ();
  ll_ht_res_if if_w ();

  ll_ht_result_t out_result, out_result_w;
  logic          out_valid, out_valid_w;
  logic          out_ready;
  logic          flush;
  logic [LW-1:0] level, level_w;
  logic [31:0]   cnt_in, cnt_out, cnt_drop;
  logic [3:0]    cnt_in_w, cnt_out_w, cnt_drop_w;

  assign if_w.result = if_m.result;
  assign if_w.valid  = if_m.valid;

  ll_ht_res_sink #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ht_res     (if_m.slave),
    .out_result (out_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .level      (level),
    .cnt_in     (cnt_in),
    .cnt_out    (cnt_out),
    .cnt_drop   (cnt_drop)
  );

  ll_ht_res_sink #(.DEPTH(DEPTH), .CNT_W(4)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .ht_res     (if_w.slave),
    .out_result (out_result_w),
    .out_valid  (out_valid_w),
    .out_ready  (out_ready),
    .flush      (flush),
    .level      (level_w),
    .cnt_in     (cnt_in_w),
    .cnt_out    (cnt_out_w),
    .cnt_drop   (cnt_drop_w)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  ll_ht_result_t q[$];
  int unsigned   m_in = 0;
  int unsigned   m_out = 0;
  int unsigned   m_drop = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ll_ht_result_t rnd();
    ll_ht_result_t r;
    r.txn_id = 8'($urandom);
    r.status = ll_ht_status_e'(2'($urandom_range(0, 3)));
    r.value  = $urandom;
    return r;
  endfunction

  function automatic ll_ht_result_t mk(input int i);
    ll_ht_result_t r;
    r.txn_id = 8'(i);
    r.status = ll_ht_status_e'(2'(i));
    r.value  = 32'hC0DE_0000 + 32'(i);
    return r;
  endfunction

  // Model state cleared on asynchronous reset
  always @(negedge rst_n) begin
    q.delete();
    m_in   = 0;
    m_out  = 0;
    m_drop = 0;
  end

  // Scoreboard: inputs change only just after posedge, so the
  // negedge view predicts exactly what transfers at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic e_rdy, e_ov;
      e_rdy = (q.size() < DEPTH) && !flush;
      e_ov  = (q.size() > 0) && !flush;
      chk("level", 64'(level), 64'(q.size()));
      chk("ready", 64'(if_m.ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("cnt_in", 64'(cnt_in), 64'(m_in));
      chk("cnt_out", 64'(cnt_out), 64'(m_out));
      chk("cnt_drop", 64'(cnt_drop), 64'(m_drop));
      if (e_ov && out_ready) begin
        chk("out_result", 64'(out_result), 64'(q[0]));
        void'(q.pop_front());
        m_out++;
        n_pop++;
      end
      if (e_rdy && if_m.valid) begin
        q.push_back(if_m.result);
        m_in++;
      end
      if (flush) begin
        m_drop += q.size();
        q.delete();
      end
    end
  end

  task automatic cyc(input logic v, input ll_ht_result_t r,
                     input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    if_m.valid  = v;
    if_m.result = r;
    out_ready   = ordy;
    flush       = fl;
  endtask

  typedef struct {
    logic          v;
    ll_ht_result_t r;
    logic          ordy;
    logic          fl;
    logic          e_rdy;
    logic          e_ov;
    logic [LW-1:0] e_lvl;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mv(input logic v, input int ri,
                              input logic ordy, input logic fl,
                              input logic e_rdy, input logic e_ov,
                              input int e_lvl);
    vec_t t;
    t.v     = v;
    t.r     = mk(ri);
    t.ordy  = ordy;
    t.fl    = fl;
    t.e_rdy = e_rdy;
    t.e_ov  = e_ov;
    t.e_lvl = LW'(e_lvl);
    return t;
  endfunction

  ll_ht_result_t zero;
  int            p0;

  initial begin
    zero        = '0;
    if_m.valid  = 1'b0;
    if_m.result = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;

    // Fill to DEPTH, one pop frees a slot a cycle later, then flush
    tbl[0] = mv(1, 1, 0, 0, 1, 0, 0);
    tbl[1] = mv(1, 2, 0, 0, 1, 1, 1);
    tbl[2] = mv(1, 3, 0, 0, 1, 1, 2);
    tbl[3] = mv(1, 4, 0, 0, 1, 1, 3);
    tbl[4] = mv(1, 5, 0, 0, 0, 1, 4);
    tbl[5] = mv(1, 5, 1, 0, 0, 1, 4);
    tbl[6] = mv(1, 5, 0, 0, 1, 1, 3);
    tbl[7] = mv(0, 0, 0, 0, 0, 1, 4);
    tbl[8] = mv(1, 6, 0, 1, 0, 0, 4);
    tbl[9] = mv(0, 0, 0, 0, 1, 0, 0);

    #2;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt_in", 64'(cnt_in), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transfer A, B, C
    cyc(1, mk(10), 1, 0);
    cyc(1, mk(11), 1, 0);
    cyc(1, mk(12), 1, 0);
    repeat (3) cyc(0, zero, 1, 0);
    chk("basic_cnt_in", 64'(cnt_in), 64'd3);
    chk("basic_cnt_out", 64'(cnt_out), 64'd3);

    // Fill / backpressure / flush-while-full table
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].r, tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 64'(if_m.ready),
          64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ov", i), 64'(out_valid),
          64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_level", i), 64'(level),
          64'(tbl[i].e_lvl));
    end
    cyc(0, zero, 0, 0);
    chk("fill_cnt_drop", 64'(cnt_drop), 64'd4);

    // Streaming 100 cycles
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      cyc(1, rnd(), 1, 0);
      @(negedge clk);
      chk("stream_level_le1", 64'(level <= 3'd1), 64'd1);
    end
    cyc(0, zero, 1, 0);
    chk("stream_beats", 64'(n_pop - p0), 64'd99);
    repeat (2) cyc(0, zero, 1, 0);

    // Flush with 3 buffered while valid is held
    cyc(1, mk(20), 0, 0);
    cyc(1, mk(21), 0, 0);
    cyc(1, mk(22), 0, 0);
    cyc(1, mk(23), 0, 1);
    cyc(0, zero, 1, 0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_cnt_drop", 64'(cnt_drop), 64'd7);
    repeat (3) cyc(0, zero, 1, 0);

    // Asynchronous reset with 2 buffered
    cyc(1, mk(30), 0, 0);
    cyc(1, mk(31), 0, 0);
    cyc(0, zero, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_cnt_in", 64'(cnt_in), 64'd0);
    chk("arst_cnt_out", 64'(cnt_out), 64'd0);
    chk("arst_cnt_drop", 64'(cnt_drop), 64'd0);

    // 18 beats through the 4-bit counter instance
    for (int i = 0; i < 18; i++) cyc(1, rnd(), 1, 0);
    repeat (3) cyc(0, zero, 1, 0);
    chk("wrap_cnt_in", 64'(cnt_in_w), 64'd2);
    chk("wrap_cnt_out", 64'(cnt_out_w), 64'd2);
    chk("wrap_cnt_drop", 64'(cnt_drop_w), 64'd0);
    chk("wrap_level", 64'(level_w), 64'd0);
    chk("wrap_ref_cnt_in", 64'(cnt_in), 64'd18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
